// File: rtl/ble_packet_sequencer.sv
// rtl/ble_packet_sequencer.sv - BLE packet RAM arbiter and LSB-first bit-stream transmit sequencer
//
// Owns the single port of the packet RAM. While idle, host writes pass straight
// through to the RAM. A transmit start hands the port to the sequencer, which
// reads a byte region (with wrap-around addressing) and serialises it LSB-first,
// one bit every BIT_CYCLES clocks, with the next byte prefetched so the stream
// has no gaps.
//
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data      host write request
//   wr_ready, wr_drop          write accepted (idle) / write discarded (busy)
//   tx_start/tx_base/tx_len    transmit start, first address, byte count (0 = ignore)
//   tx_abort                   terminate an active transmission
//   tx_busy, tx_done           transmission active / normal completion pulse
//   bit_out, bit_valid         serial bit / first cycle of each bit period
//   mem_ce/we/addr/data, mem_q RAM port (registered output, RD_LAT cycle read)
//   mem_rst                    RAM output reset, released through a 2-flop synchroniser

module ble_packet_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int BIT_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  output logic              wr_drop,
  input  logic              tx_start,
  input  logic [ADDR_W-1:0] tx_base,
  input  logic [ADDR_W:0]   tx_len,
  input  logic              tx_abort,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  input  logic [7:0]        mem_q,
  output logic              mem_rst
);

  localparam int BYTE_CYCLES = 8 * BIT_CYCLES;
  localparam int CW          = $clog2(BYTE_CYCLES + 1);
  localparam int BW          = $clog2(BIT_CYCLES + 1);
  localparam int LW          = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;     // address currently presented to the RAM
  logic [LW-1:0]     bytes_left;  // bytes still to send after the one in shift_reg
  logic [7:0]        shift_reg;
  logic [7:0]        next_reg;
  logic [CW-1:0]     byte_cyc;    // cycle within FETCH, or within the current byte
  logic [BW-1:0]     cyc_cnt;     // cycle within the current bit
  logic [1:0]        rst_sync;

  logic idle;
  assign idle = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_addr    <= '0;
      bytes_left <= '0;
      shift_reg  <= '0;
      next_reg   <= '0;
      byte_cyc   <= '0;
      cyc_cnt    <= '0;
    end else if (!idle && tx_abort) begin
      // In-flight read data is simply never captured.
      state    <= IDLE;
      byte_cyc <= '0;
      cyc_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_start && (tx_len != '0)) begin
            rd_addr    <= tx_base;
            bytes_left <= tx_len - LW'(1);
            byte_cyc   <= '0;
            state      <= FETCH;
          end
        end

        FETCH: begin
          if (byte_cyc == CW'(RD_LAT)) begin
            shift_reg <= mem_q;
            byte_cyc  <= '0;
            cyc_cnt   <= '0;
            state     <= SHIFT;
            // Moving the address now makes the first cycle of bit 0 issue the prefetch.
            if (bytes_left != '0) rd_addr <= rd_addr + ADDR_W'(1);
          end else begin
            byte_cyc <= byte_cyc + CW'(1);
          end
        end

        SHIFT: begin
          if ((byte_cyc == CW'(RD_LAT)) && (bytes_left != '0)) next_reg <= mem_q;

          if (cyc_cnt == BW'(BIT_CYCLES - 1)) begin
            cyc_cnt   <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
          end else begin
            cyc_cnt <= cyc_cnt + BW'(1);
          end

          // End of bit 7: the byte-boundary load overrides the shift above.
          if (byte_cyc == CW'(BYTE_CYCLES - 1)) begin
            byte_cyc <= '0;
            if (bytes_left == '0) begin
              state <= DONE;
            end else begin
              shift_reg  <= next_reg;
              bytes_left <= bytes_left - LW'(1);
              if (bytes_left != LW'(1)) rd_addr <= rd_addr + ADDR_W'(1);
            end
          end else begin
            byte_cyc <= byte_cyc + CW'(1);
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  // RAM reset release is synchronised so it never deasserts mid-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign mem_rst   = ~rst_sync[1];
  assign wr_ready  = idle;
  assign wr_drop   = wr_en & ~idle;
  assign tx_busy   = ~idle;
  assign tx_done   = (state == DONE);
  assign bit_valid = (state == SHIFT) && (cyc_cnt == '0);
  assign bit_out   = (state == SHIFT) && shift_reg[0];
  assign mem_ce    = idle ? wr_en : 1'b1;
  assign mem_we    = idle & wr_en;
  assign mem_addr  = idle ? wr_addr : rd_addr;
  assign mem_data  = idle ? wr_data : 8'h00;

endmodule

// File: tb/tb_ble_packet_sequencer.sv
// tb/tb_ble_packet_sequencer.sv - self-checking bench for ble_packet_sequencer
module tb_ble_packet_sequencer;

  localparam int BIT_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, wr_drop;
  logic       tx_start = 1'b0;
  logic [7:0] tx_base = 8'h00;
  logic [8:0] tx_len = 9'd0;
  logic       tx_abort = 1'b0;
  logic       tx_busy, tx_done, bit_out, bit_valid;
  logic       mem_ce, mem_we, mem_rst;
  logic [7:0] mem_addr, mem_data;
  logic [7:0] mem_q;

  always #5 clk = ~clk;

  ble_packet_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_drop(wr_drop),
    .tx_start(tx_start), .tx_base(tx_base), .tx_len(tx_len), .tx_abort(tx_abort),
    .tx_busy(tx_busy), .tx_done(tx_done), .bit_out(bit_out), .bit_valid(bit_valid),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_q(mem_q), .mem_rst(mem_rst)
  );

  // 256x8 RAM, registered output, 2-cycle read latency.
  logic [7:0] ram [256];
  logic [7:0] q1;
  always @(posedge clk) begin
    if (mem_rst) begin
      q1    <= 8'h00;
      mem_q <= 8'h00;
    end else if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= mem_data;
      q1    <= ram[mem_addr];
      mem_q <= q1;
    end
  end

  // Reference: what the host has successfully written.
  logic [7:0] ref_mem [256];

  int passed = 0;
  int total  = 0;

  logic       r_bits[$];
  logic [7:0] r_addr[$];
  int r_first_busy, r_first_bv, r_last_bv, r_done_rel, r_done_cnt, r_bv_cnt;
  int r_timing_err, r_drop_cnt, r_we_cnt, r_ce_cnt, r_busy_cnt, r_abort_rel;
  logic r_busy_after, r_abort_idle;

  function automatic int bit_errs(input logic [7:0] base, input int nbits);
    int errs;
    int n;
    logic [7:0] b;
    n    = (r_bits.size() < nbits) ? r_bits.size() : nbits;
    errs = (r_bits.size() > nbits) ? r_bits.size() - nbits : nbits - r_bits.size();
    for (int i = 0; i < n; i++) begin
      b = ref_mem[8'(int'(base) + i / 8)];
      if (r_bits[i] !== b[i % 8]) errs++;
    end
    return errs;
  endfunction

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic transmit(input logic [7:0] base, input int len, input int budget,
                          input int drop_from = -1, input int drop_to = -1,
                          input int abort_bv = 0, input int restart_rel = -1,
                          input logic same_wr = 1'b0, input logic [7:0] sw_addr = 8'h00,
                          input logic [7:0] sw_data = 8'h00);
    r_bits.delete(); r_addr.delete();
    r_first_busy = -1; r_first_bv = -1; r_last_bv = -1; r_done_rel = -1;
    r_done_cnt = 0; r_bv_cnt = 0; r_timing_err = 0; r_drop_cnt = 0;
    r_we_cnt = 0; r_ce_cnt = 0; r_busy_cnt = 0; r_abort_rel = -1;
    r_busy_after = 1'b1; r_abort_idle = 1'b0;
    @(negedge clk);
    tx_start = 1'b1; tx_base = base; tx_len = 9'(len);
    if (same_wr) begin
      wr_en = 1'b1; wr_addr = sw_addr; wr_data = sw_data;
      ref_mem[sw_addr] = sw_data;
    end
    for (int rel = 1; rel <= budget; rel++) begin
      @(negedge clk);
      tx_start = 1'b0; wr_en = 1'b0; tx_abort = 1'b0;
      if (tx_busy) begin
        r_busy_cnt++;
        if (r_first_busy < 0) r_first_busy = rel;
      end
      if (bit_valid) begin
        if (r_last_bv >= 0 && rel - r_last_bv != BIT_CYCLES) r_timing_err++;
        if (r_first_bv < 0) r_first_bv = rel;
        r_last_bv = rel;
        r_bits.push_back(bit_out);
        r_bv_cnt++;
      end else if (tx_busy && !tx_done && r_bits.size() > 0 && bit_out !== r_bits[$]) begin
        r_timing_err++;
      end
      if (tx_done) begin
        r_done_cnt++;
        r_done_rel = rel;
      end
      if (r_abort_rel >= 0 && rel == r_abort_rel + 1)
        r_abort_idle = wr_ready && !tx_busy && !bit_valid && !bit_out;
      if (r_done_rel >= 0 && rel == r_done_rel + 1) r_busy_after = tx_busy;
      if (rel >= drop_from && rel <= drop_to) begin
        wr_en   = 1'b1;
        wr_addr = base + 8'($urandom_range(0, len - 1));
        wr_data = ~ref_mem[wr_addr];
      end
      if (rel == restart_rel) begin
        tx_start = 1'b1; tx_base = 8'h00; tx_len = 9'd1;
      end
      if (abort_bv > 0 && bit_valid && r_bv_cnt == abort_bv && r_abort_rel < 0) begin
        tx_abort = 1'b1;
        r_abort_rel = rel;
      end
      #1;
      if (wr_drop) r_drop_cnt++;
      if (mem_we)  r_we_cnt++;
      if (mem_ce)  r_ce_cnt++;
      r_addr.push_back(mem_addr);
      if (r_done_rel >= 0 && rel > r_done_rel) break;
    end
    tx_start = 1'b0; wr_en = 1'b0; tx_abort = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); else passed++;
    total++; if (mem_rst !== 1'b1) $display("FAIL reset_mem_rst got=%b exp=1", mem_rst); else passed++;
    total++;
    if ({tx_busy, tx_done, bit_out, bit_valid, mem_ce, mem_we, wr_drop} !== 7'b0)
      $display("FAIL reset_outputs got=%b exp=0000000",
               {tx_busy, tx_done, bit_out, bit_valid, mem_ce, mem_we, wr_drop});
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (mem_rst !== 1'b1) $display("FAIL reset_mem_rst_edge1 got=%b exp=1", mem_rst); else passed++;
    @(negedge clk);
    total++; if (mem_rst !== 1'b0) $display("FAIL reset_mem_rst_edge2 got=%b exp=0", mem_rst); else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    host_write(8'h10, 8'hA5);
    host_write(8'h11, 8'h3C);
    transmit(8'h10, 2, 160);
    total++; if (r_first_busy !== 1) $display("FAIL basic_busy_rise got=%0d exp=1", r_first_busy); else passed++;
    total++; if (r_first_bv !== 4) $display("FAIL basic_first_bv got=%0d exp=4", r_first_bv); else passed++;
    total++; if (r_done_rel !== 132) $display("FAIL basic_done_time got=%0d exp=132", r_done_rel); else passed++;
    total++; if (r_bv_cnt !== 16) $display("FAIL basic_bv_count got=%0d exp=16", r_bv_cnt); else passed++;
    total++; if (bit_errs(8'h10, 16) !== 0) $display("FAIL basic_bits errors=%0d exp=0", bit_errs(8'h10, 16)); else passed++;
    total++; if (r_timing_err !== 0) $display("FAIL basic_bit_timing errors=%0d exp=0", r_timing_err); else passed++;
    total++; if (r_busy_after !== 1'b0) $display("FAIL basic_busy_after_done got=%b exp=0", r_busy_after); else passed++;
  endtask

  task automatic test_wrap;
    host_write(8'hFF, 8'h01);
    host_write(8'h00, 8'h80);
    transmit(8'hFF, 2, 160);
    total++; if (r_addr[0] !== 8'hFF) $display("FAIL wrap_addr0 got=%h exp=ff", r_addr[0]); else passed++;
    total++; if (r_addr[3] !== 8'h00) $display("FAIL wrap_addr1 got=%h exp=00", r_addr[3]); else passed++;
    total++; if (bit_errs(8'hFF, 16) !== 0) $display("FAIL wrap_bits errors=%0d exp=0", bit_errs(8'hFF, 16)); else passed++;
    total++; if (r_done_cnt !== 1) $display("FAIL wrap_done_count got=%0d exp=1", r_done_cnt); else passed++;
  endtask

  task automatic test_drop;
    logic [7:0] base;
    base = 8'($urandom);
    for (int i = 0; i < 3; i++) host_write(base + 8'(i), 8'($urandom));
    transmit(base, 3, 220, 70, 74, 0, 20);
    total++; if (r_drop_cnt !== 5) $display("FAIL drop_pulses got=%0d exp=5", r_drop_cnt); else passed++;
    total++; if (r_we_cnt !== 0) $display("FAIL drop_mem_we got=%0d exp=0", r_we_cnt); else passed++;
    total++; if (bit_errs(base, 24) !== 0) $display("FAIL drop_bits errors=%0d exp=0", bit_errs(base, 24)); else passed++;
    total++; if (r_done_rel !== 196) $display("FAIL busy_start_ignored done=%0d exp=196", r_done_rel); else passed++;
    transmit(base, 3, 220);
    total++; if (bit_errs(base, 24) !== 0) $display("FAIL drop_readback errors=%0d exp=0", bit_errs(base, 24)); else passed++;
  endtask

  task automatic test_len_zero;
    transmit(8'h30, 0, 12);
    total++; if (r_busy_cnt !== 0) $display("FAIL len0_busy cycles=%0d exp=0", r_busy_cnt); else passed++;
    total++; if (r_ce_cnt !== 0) $display("FAIL len0_mem_ce cycles=%0d exp=0", r_ce_cnt); else passed++;
    total++; if (r_bv_cnt !== 0) $display("FAIL len0_bits got=%0d exp=0", r_bv_cnt); else passed++;
  endtask

  task automatic test_abort;
    logic [7:0] base;
    base = 8'($urandom);
    for (int i = 0; i < 4; i++) host_write(base + 8'(i), 8'($urandom));
    transmit(base, 4, 400, -1, -1, 3);
    total++; if (r_bv_cnt !== 3) $display("FAIL abort_bv_count got=%0d exp=3", r_bv_cnt); else passed++;
    total++; if (r_done_cnt !== 0) $display("FAIL abort_no_done got=%0d exp=0", r_done_cnt); else passed++;
    total++; if (r_abort_idle !== 1'b1) $display("FAIL abort_idle_next got=%b exp=1", r_abort_idle); else passed++;
    total++; if (bit_errs(base, 3) !== 0) $display("FAIL abort_bits errors=%0d exp=0", bit_errs(base, 3)); else passed++;
  endtask

  task automatic test_same_cycle;
    transmit(8'h20, 1, 100, -1, -1, 0, -1, 1'b1, 8'h20, 8'h5A);
    total++; if (bit_errs(8'h20, 8) !== 0) $display("FAIL same_cycle_bits errors=%0d exp=0", bit_errs(8'h20, 8)); else passed++;
    total++; if (r_done_rel !== 68) $display("FAIL same_cycle_done got=%0d exp=68", r_done_rel); else passed++;
  endtask

  task automatic test_random;
    logic [7:0] base;
    int len;
    for (int k = 0; k < 6; k++) begin
      base = 8'($urandom);
      len  = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) host_write(base + 8'(i), 8'($urandom));
      transmit(base, len, 4 + 64 * len + 10);
      total++; if (bit_errs(base, 8 * len) !== 0) $display("FAIL rand%0d_bits errors=%0d exp=0", k, bit_errs(base, 8 * len)); else passed++;
      total++; if (r_bv_cnt !== 8 * len) $display("FAIL rand%0d_bv_count got=%0d exp=%0d", k, r_bv_cnt, 8 * len); else passed++;
      total++; if (r_done_rel !== 4 + 64 * len) $display("FAIL rand%0d_done got=%0d exp=%0d", k, r_done_rel, 4 + 64 * len); else passed++;
      total++; if (r_timing_err !== 0) $display("FAIL rand%0d_timing errors=%0d exp=0", k, r_timing_err); else passed++;
    end
  endtask

  task automatic test_full;
    logic [7:0] base;
    for (int i = 0; i < 256; i++) host_write(8'(i), 8'($urandom));
    base = 8'($urandom);
    transmit(base, 256, 4 + 64 * 256 + 10);
    total++; if (bit_errs(base, 2048) !== 0) $display("FAIL full_bits errors=%0d exp=0", bit_errs(base, 2048)); else passed++;
    total++; if (r_done_rel !== 4 + 64 * 256) $display("FAIL full_done got=%0d exp=%0d", r_done_rel, 4 + 64 * 256); else passed++;
  endtask

  task automatic test_reset_mid;
    int done_seen;
    done_seen = 0;
    for (int i = 0; i < 3; i++) host_write(8'h40 + 8'(i), 8'($urandom));
    @(negedge clk);
    tx_start = 1'b1; tx_base = 8'h40; tx_len = 9'd3;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (30) @(negedge clk);
    total++; if (tx_busy !== 1'b1) $display("FAIL rstmid_busy_before got=%b exp=1", tx_busy); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({tx_busy, bit_valid, bit_out, tx_done, mem_ce, wr_ready, mem_rst} !== 7'b0000011)
      $display("FAIL rstmid_async got=%b exp=0000011",
               {tx_busy, bit_valid, bit_out, tx_done, mem_ce, wr_ready, mem_rst});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if (tx_done) done_seen++;
    total++; if (mem_rst !== 1'b1) $display("FAIL rstmid_mem_rst_edge1 got=%b exp=1", mem_rst); else passed++;
    @(negedge clk);
    if (tx_done) done_seen++;
    total++; if (mem_rst !== 1'b0) $display("FAIL rstmid_mem_rst_edge2 got=%b exp=0", mem_rst); else passed++;
    total++; if (done_seen !== 0 || tx_busy !== 1'b0) $display("FAIL rstmid_quiet done=%0d busy=%b exp=0/0", done_seen, tx_busy); else passed++;
    transmit(8'h40, 3, 220);
    total++; if (bit_errs(8'h40, 24) !== 0) $display("FAIL rstmid_readback errors=%0d exp=0", bit_errs(8'h40, 24)); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    test_reset();
    test_basic();
    test_wrap();
    test_drop();
    test_len_zero();
    test_abort();
    test_same_cycle();
    test_random();
    test_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
